// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control inputs and fetch-address outputs of the program-counter stage
interface pc_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             PCWrite_i;
    logic             exc_i;
    logic             branch_i;
    logic [XLEN-1:0]  branch_target_i;
    logic             jump_i;
    logic [XLEN-1:0]  jump_target_i;
    logic             call_i;
    logic             ret_i;
    logic [XLEN-1:0]  pc_o;
    logic             valid_o;
    logic             redirect_o;
    logic [CNT_W-1:0] redirect_cnt_o;
    logic             ras_underflow_o;

    modport master (
        output start_i, PCWrite_i, exc_i, branch_i, branch_target_i,
               jump_i, jump_target_i, call_i, ret_i,
        input  pc_o, valid_o, redirect_o, redirect_cnt_o, ras_underflow_o
    );

    modport slave (
        input  start_i, PCWrite_i, exc_i, branch_i, branch_target_i,
               jump_i, jump_target_i, call_i, ret_i,
        output pc_o, valid_o, redirect_o, redirect_cnt_o, ras_underflow_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - IF-stage program counter with priority redirect and optional return stack
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] EXC_VEC   = 'h100,
    parameter int              STEP      = 4,
    parameter int              CNT_W     = 16,
    parameter int              RAS_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pc_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  pc_seq;
    logic             redirect_q;
    logic             redirect_next;
    logic             underflow_q;
    logic             underflow_next;
    logic [CNT_W-1:0] cnt_q;
    logic             run_cyc;

    assign pc_seq  = pc_q + XLEN'(STEP);
    // Dropping start_i takes effect in the same cycle, so redirects are ignored then too.
    assign run_cyc = (state == RUN) && bus.start_i;

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [PW:0]     ras_cnt;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] ras_top;

    // ras_ptr points at the next free slot; wrapping overwrites the oldest entry.
    assign ras_top = ras_mem[ras_ptr - PW'(1)];

    always_ff @(posedge clk_i) begin
        if (push) begin
            ras_mem[ras_ptr] <= pc_seq;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (push) begin
            ras_ptr <= ras_ptr + PW'(1);
            if (ras_cnt != (PW+1)'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + (PW+1)'(1);
            end
        end else if (pop) begin
            ras_ptr <= ras_ptr - PW'(1);
            ras_cnt <= ras_cnt - (PW+1)'(1);
        end
    end
`else
    logic unused_call;
    assign unused_call = bus.call_i;
`endif

    always_comb begin
        pc_next        = pc_q;
        redirect_next  = 1'b0;
        underflow_next = 1'b0;
`ifdef PC_RAS_EN
        push           = 1'b0;
        pop            = 1'b0;
`endif
        if (run_cyc) begin
            if (bus.exc_i) begin
                pc_next       = EXC_VEC;
                redirect_next = 1'b1;
            end else if (bus.branch_i) begin
                pc_next       = bus.branch_target_i;
                redirect_next = 1'b1;
            end else if (bus.jump_i && bus.PCWrite_i) begin
                pc_next       = bus.jump_target_i;
                redirect_next = 1'b1;
`ifdef PC_RAS_EN
                push          = bus.call_i;
`endif
            end else if (bus.ret_i && bus.PCWrite_i) begin
`ifdef PC_RAS_EN
                if (ras_cnt != '0) begin
                    pc_next       = ras_top;
                    redirect_next = 1'b1;
                    pop           = 1'b1;
                end else begin
                    pc_next        = pc_seq;
                    underflow_next = 1'b1;
                end
`else
                pc_next = pc_seq;
`endif
            end else if (bus.PCWrite_i) begin
                pc_next = pc_seq;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            pc_q        <= RESET_VEC;
            redirect_q  <= 1'b0;
            underflow_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE:    if (bus.start_i)  state <= RUN;
                RUN:     if (!bus.start_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            pc_q        <= pc_next;
            redirect_q  <= redirect_next;
            underflow_q <= underflow_next;
            if (redirect_next && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_o            = pc_q;
    assign bus.valid_o         = (state == RUN);
    assign bus.redirect_o      = redirect_q;
    assign bus.redirect_cnt_o  = cnt_q;
    assign bus.ras_underflow_o = underflow_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a queue-based reference model
module tb_pc_sequencer;
    localparam int RAS_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32), .CNT_W(16)) sif ();
    pc_sequencer_if #(.XLEN(32), .CNT_W(2))  sif2 ();

    pc_sequencer #(.XLEN(32), .CNT_W(16), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(sif));
    pc_sequencer #(.XLEN(32), .CNT_W(2), .RAS_DEPTH(RAS_DEPTH)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .bus(sif2));

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    bit          m_run, m_red, m_uf;
    int unsigned m_cnt;
    logic [31:0] m_stack[$];

    task automatic model_reset();
        m_pc = 32'h0; m_run = 0; m_red = 0; m_uf = 0; m_cnt = 0;
        m_stack.delete();
    endtask

    // Behaviour of one clock edge, computed from the inputs as seen at that edge.
    task automatic model_step();
        m_red = 0;
        m_uf  = 0;
        if (!m_run) begin
            m_run = sif.start_i;
        end else if (!sif.start_i) begin
            m_run = 0;
        end else if (sif.exc_i) begin
            m_pc = 32'h100; m_red = 1;
        end else if (sif.branch_i) begin
            m_pc = sif.branch_target_i; m_red = 1;
        end else if (sif.jump_i && sif.PCWrite_i) begin
`ifdef PC_RAS_EN
            if (sif.call_i) begin
                m_stack.push_back(m_pc + 32'd4);
                if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
            end
`endif
            m_pc = sif.jump_target_i; m_red = 1;
        end else if (sif.ret_i && sif.PCWrite_i) begin
`ifdef PC_RAS_EN
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back(); m_red = 1;
            end else begin
                m_pc = m_pc + 32'd4; m_uf = 1;
            end
`else
            m_pc = m_pc + 32'd4;
`endif
        end else if (sif.PCWrite_i) begin
            m_pc = m_pc + 32'd4;
        end
        if (m_red && m_cnt < 65535) m_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit st, input bit pw, input bit ex, input bit br,
                         input logic [31:0] bt, input bit jp, input logic [31:0] jt,
                         input bit cl, input bit rt);
        sif.start_i = st; sif.PCWrite_i = pw; sif.exc_i = ex; sif.branch_i = br;
        sif.branch_target_i = bt; sif.jump_i = jp; sif.jump_target_i = jt;
        sif.call_i = cl; sif.ret_i = rt;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sif2.start_i = 0; sif2.PCWrite_i = 0; sif2.exc_i = 0; sif2.branch_i = 0;
        sif2.branch_target_i = 0; sif2.jump_i = 0; sif2.jump_target_i = 0;
        sif2.call_i = 0; sif2.ret_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (sif.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", sif.pc_o); end
        checks++; if (sif.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sif.valid_o); end
        checks++; if (sif.redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", sif.redirect_o); end
        checks++; if (sif.redirect_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", sif.redirect_cnt_o); end
        checks++; if (sif.ras_underflow_o !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b expected 0", sif.ras_underflow_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (sif.pc_o !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, sif.pc_o, 32'(i * 4)); end
            checks++; if (sif.valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, sif.valid_o); end
        end
    endtask

    task automatic test_stall_priority();
        int unsigned cnt_before;
        drive(1, 1, 0, 1, 32'h20, 0, 0, 0, 0); tick();
        checks++; if (sif.pc_o !== 32'h20) begin errors++; $display("FAIL stall_setup_pc: got %h expected 20", sif.pc_o); end
        cnt_before = m_cnt;
        drive(1, 0, 0, 0, 0, 1, 32'h80, 0, 0); tick();
        checks++; if (sif.pc_o !== 32'h20) begin errors++; $display("FAIL stall_jump_pc: got %h expected 20", sif.pc_o); end
        checks++; if (sif.redirect_o !== 1'b0) begin errors++; $display("FAIL stall_jump_redirect: got %b expected 0", sif.redirect_o); end
        drive(1, 0, 0, 1, 32'h40, 0, 0, 0, 0); tick();
        checks++; if (sif.pc_o !== 32'h40) begin errors++; $display("FAIL stall_branch_pc: got %h expected 40", sif.pc_o); end
        checks++; if (sif.redirect_o !== 1'b1) begin errors++; $display("FAIL stall_branch_redirect: got %b expected 1", sif.redirect_o); end
        checks++; if (sif.redirect_cnt_o !== 16'(cnt_before + 1)) begin errors++; $display("FAIL stall_branch_cnt: got %0d expected %0d", sif.redirect_cnt_o, cnt_before + 1); end
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (sif.redirect_o !== 1'b0) begin errors++; $display("FAIL redirect_pulse_width: got %b expected 0", sif.redirect_o); end
    endtask

    task automatic test_exception_wrap();
        drive(1, 1, 0, 1, 32'h40, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 1, 32'h500, 1, 32'h600, 0, 0); tick();
        checks++; if (sif.pc_o !== 32'h100) begin errors++; $display("FAIL exc_pc: got %h expected 100", sif.pc_o); end
        checks++; if (sif.redirect_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL exc_cnt: got %0d expected %0d", sif.redirect_cnt_o, m_cnt); end
        drive(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (sif.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", sif.pc_o); end
        checks++; if (sif.redirect_o !== 1'b0) begin errors++; $display("FAIL wrap_redirect: got %b expected 0", sif.redirect_o); end
    endtask

    task automatic test_ras();
`ifdef PC_RAS_EN
        drive(1, 1, 0, 1, 32'h10, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 1, 32'h200, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1); tick();
        checks++; if (sif.pc_o !== 32'h14) begin errors++; $display("FAIL ras_ret_pc: got %h expected 14", sif.pc_o); end
        checks++; if (sif.redirect_o !== 1'b1) begin errors++; $display("FAIL ras_ret_redirect: got %b expected 1", sif.redirect_o); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0, 1, 32'h1000 + 32'(i) * 32'h100, 1, 0); tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 1); tick();
            checks++; if (sif.pc_o !== m_pc) begin errors++; $display("FAIL ras_pop_pc[%0d]: got %h expected %h", i, sif.pc_o, m_pc); end
            checks++; if (sif.ras_underflow_o !== (i == 4)) begin errors++; $display("FAIL ras_uf[%0d]: got %b expected %b", i, sif.ras_underflow_o, i == 4); end
        end
        checks++; if (sif.redirect_o !== 1'b0) begin errors++; $display("FAIL ras_uf_redirect: got %b expected 0", sif.redirect_o); end
`else
        logic [31:0] pc_before;
        pc_before = sif.pc_o;
        drive(1, 1, 0, 0, 0, 0, 0, 1, 1); tick();
        checks++; if (sif.pc_o !== pc_before + 32'd4) begin errors++; $display("FAIL noras_ret_pc: got %h expected %h", sif.pc_o, pc_before + 32'd4); end
        checks++; if (sif.redirect_o !== 1'b0) begin errors++; $display("FAIL noras_ret_redirect: got %b expected 0", sif.redirect_o); end
        checks++; if (sif.ras_underflow_o !== 1'b0) begin errors++; $display("FAIL noras_uf: got %b expected 0", sif.ras_underflow_o); end
`endif
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_idle_and_async_reset();
        drive(1, 1, 0, 1, 32'h30, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 1, 32'h80, 0, 0); tick();
        checks++; if (sif.pc_o !== 32'h30) begin errors++; $display("FAIL idle_pc: got %h expected 30", sif.pc_o); end
        checks++; if (sif.valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", sif.valid_o); end
        drive(0, 1, 1, 1, 32'h90, 1, 32'h80, 1, 1); tick();
        checks++; if (sif.pc_o !== 32'h30) begin errors++; $display("FAIL idle_ignore_pc: got %h expected 30", sif.pc_o); end
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++; if (sif.pc_o !== 32'h30) begin errors++; $display("FAIL first_run_pc: got %h expected 30", sif.pc_o); end
        drive(1, 1, 0, 1, 32'h70, 0, 0, 0, 0); tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (sif.pc_o !== 32'h0) begin errors++; $display("FAIL async_rst_pc: got %h expected 0", sif.pc_o); end
        checks++; if (sif.redirect_cnt_o !== 16'h0) begin errors++; $display("FAIL async_rst_cnt: got %0d expected 0", sif.redirect_cnt_o); end
        checks++; if (sif.valid_o !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", sif.valid_o); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        sif2.start_i = 1; tick();
        for (int k = 1; k <= 5; k++) begin
            sif2.branch_i = 1; sif2.branch_target_i = $urandom; tick();
            checks++; if (sif2.redirect_cnt_o !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, sif2.redirect_cnt_o, (k > 3) ? 3 : k); end
        end
        sif2.branch_i = 0; sif2.start_i = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 8, $urandom,
                  $urandom_range(0, 99) < 15, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 1), $urandom_range(0, 99) < 15);
            tick();
            checks++; if (sif.pc_o !== m_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", n, sif.pc_o, m_pc); end
            checks++; if (sif.valid_o !== m_run) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, sif.valid_o, m_run); end
            checks++; if (sif.redirect_o !== m_red) begin errors++; $display("FAIL rand_redirect[%0d]: got %b expected %b", n, sif.redirect_o, m_red); end
            checks++; if (sif.redirect_cnt_o !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, sif.redirect_cnt_o, m_cnt); end
            checks++; if (sif.ras_underflow_o !== m_uf) begin errors++; $display("FAIL rand_uf[%0d]: got %b expected %b", n, sif.ras_underflow_o, m_uf); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_priority();
        test_exception_wrap();
        test_ras();
        test_idle_and_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
